// File: rtl/stage_if.sv
// -----------------------------------------------------------------------------
// stage_if : instruction-fetch stage, producing the IF/ID pipeline register.
//
// Owns the fetch PC and issues one word fetch at a time over a req/ack
// handshake that tolerates any memory latency, including a zero-wait ack in
// the request cycle. Returned words go into a small FIFO so that decode stalls
// never lose a fetch. A redirect from downstream flushes the FIFO and the
// IF/ID register. If a fetch is still in flight, its response is dropped
// later in the DISCARD state.
//
// Parameters:
//   RESET_PC    fetch address after reset (word aligned)
//   FIFO_DEPTH  fetch buffer entries, 2 or 4
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   imem_req/imem_addr           fetch request and word address
//   imem_ack/imem_rdata          fetch response; data valid when ack=1
//   redirect_valid/redirect_pc   one-cycle flush and refetch pulse
//   id_stall                     decode cannot take a new instruction
//   id_valid/id_instr/id_pc/id_pc_plus4   IF/ID register outputs
//
// Optional feature (macro IF_BUBBLE_CNT_EN):
//   bubble_cnt  saturating count of cycles in which the IF/ID register
//               loaded while the FIFO was empty and no redirect was active.
// -----------------------------------------------------------------------------
module stage_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef IF_BUBBLE_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {FETCH, DISCARD} state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic [31:0]       disc_addr;   // address of the orphaned in-flight fetch
    logic              run;         // holds requests off until the first edge after reset

    logic [31:0]       fifo_pc    [FIFO_DEPTH];
    logic [31:0]       fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              disc;
    logic              fire;
    logic              push;
    logic              pop;
    logic              id_load;
    logic              fifo_empty;

    logic              unused_pc_lsbs;
    assign unused_pc_lsbs = &{1'b0, redirect_pc[1:0]};

    always_comb begin
        disc       = (state == DISCARD);
        fifo_empty = (count == '0);
        // The request gate uses the pre-pop count. This is conservative: an
        // accepted request always has a free slot.
        imem_req   = run && (disc || (count < DEPTH_C));
        imem_addr  = disc ? disc_addr : fetch_pc;
        fire       = imem_req && imem_ack;
        push       = fire && !disc && !redirect_valid;
        id_load    = !id_stall || !id_valid;
        pop        = id_load && !fifo_empty && !redirect_valid;
    end

    // Fetch FSM and PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            disc_addr <= RESET_PC;
            run       <= 1'b0;
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                if (!disc && imem_req && !imem_ack) begin
                    // Request stays on the bus with its old address until acked.
                    state     <= DISCARD;
                    disc_addr <= fetch_pc;
                end else if (disc && imem_ack) begin
                    state <= FETCH;
                end
            end else if (disc) begin
                if (imem_ack)
                    state <= FETCH;
            end else if (fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= fetch_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    // IF/ID register. Redirect wins over a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
        end else if (id_load) begin
            if (!fifo_empty) begin
                id_valid    <= 1'b1;
                id_instr    <= fifo_instr[rd_ptr];
                id_pc       <= fifo_pc[rd_ptr];
                id_pc_plus4 <= fifo_pc[rd_ptr] + 32'd4;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

`ifdef IF_BUBBLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (id_load && fifo_empty && !redirect_valid && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hDEAD_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef IF_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Memory model: each word's contents are derived from its address.
    assign imem_rdata = imem_addr ^ KEY;

    stage_if #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef IF_BUBBLE_CNT_EN
        ,
        .bubble_cnt     (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; id_stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; id_stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== RST_PC) $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC); else pass_cnt++;
        total_cnt++; if (id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b want 0", id_valid); else pass_cnt++;
        total_cnt++; if ({id_instr, id_pc, id_pc_plus4} !== 96'h0)
            $display("FAIL rst_id_regs: got %h %h %h want all 0", id_instr, id_pc, id_pc_plus4); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if ({imem_req, imem_addr} !== {1'b1, RST_PC})
            $display("FAIL rst_first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RST_PC); else pass_cnt++;
    endtask

    // Zero-wait memory gives one fetch per cycle with no gaps.
    task automatic test_stream();
        logic [31:0] pc;
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total_cnt++; if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)})
                $display("FAIL stream_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i)); else pass_cnt++;
            if (i < 2) begin
                total_cnt++; if (id_valid !== 1'b0) $display("FAIL stream_early_valid[%0d]: got %b want 0", i, id_valid); else pass_cnt++;
            end else begin
                pc = 32'(4 * (i - 2));
                total_cnt++; if ({id_valid, id_pc, id_pc_plus4, id_instr} !== {1'b1, pc, pc + 32'd4, pc ^ KEY})
                    $display("FAIL stream_id[%0d]: got v=%b pc=%h p4=%h ins=%h want v=1 pc=%h p4=%h ins=%h",
                             i, id_valid, id_pc, id_pc_plus4, id_instr, pc, pc + 32'd4, pc ^ KEY); else pass_cnt++;
            end
        end
    endtask

    // Stall for 6 cycles at id_pc=0x4: outputs hold, request stops once the
    // 2-entry FIFO is full, and after release nothing is lost or duplicated.
    task automatic test_stall();
        logic [31:0] pc;
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 3) begin
                total_cnt++; if ({id_valid, id_pc} !== {1'b1, 32'h4})
                    $display("FAIL stall_entry: got v=%b pc=%h want v=1 pc=00000004", id_valid, id_pc); else pass_cnt++;
                id_stall = 1'b1;
            end
            if (i >= 4 && i <= 9) begin
                total_cnt++; if ({id_valid, id_pc, id_pc_plus4, imem_req} !== {1'b1, 32'h4, 32'h8, 1'b0})
                    $display("FAIL stall_hold[%0d]: got v=%b pc=%h p4=%h req=%b want v=1 pc=4 p4=8 req=0",
                             i, id_valid, id_pc, id_pc_plus4, imem_req); else pass_cnt++;
            end
            if (i == 9) id_stall = 1'b0;
            if (i == 10) begin
                total_cnt++; if ({imem_req, imem_addr} !== {1'b1, 32'h10})
                    $display("FAIL stall_resume_req: got req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr); else pass_cnt++;
            end
            if (i >= 10) begin
                pc = 32'h8 + 32'(4 * (i - 10));
                total_cnt++; if ({id_valid, id_pc, id_instr} !== {1'b1, pc, pc ^ KEY})
                    $display("FAIL stall_release[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                             i, id_valid, id_pc, id_instr, pc, pc ^ KEY); else pass_cnt++;
            end
        end
    endtask

    // Redirect during a delayed ack: old request holds, its data is dropped.
    task automatic test_redirect_wait();
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        total_cnt++; if (imem_addr !== 32'h10) $display("FAIL rw_setup_addr: got %h want 00000010", imem_addr); else pass_cnt++;
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        for (int w = 1; w <= 6; w++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            if (w <= 3) begin
                total_cnt++; if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h10, 1'b0})
                    $display("FAIL rw_hold[%0d]: got req=%b addr=%h v=%b want req=1 addr=00000010 v=0",
                             w, imem_req, imem_addr, id_valid); else pass_cnt++;
                if (w == 3) imem_ack = 1'b1;
            end else if (w == 4) begin
                total_cnt++; if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h100, 1'b0})
                    $display("FAIL rw_newaddr: got req=%b addr=%h v=%b want req=1 addr=00000100 v=0",
                             imem_req, imem_addr, id_valid); else pass_cnt++;
            end else if (w == 5) begin
                total_cnt++; if (id_valid !== 1'b0) $display("FAIL rw_gap: got v=%b want 0", id_valid); else pass_cnt++;
            end else begin
                total_cnt++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h100, 32'h100 ^ KEY})
                    $display("FAIL rw_first: got v=%b pc=%h ins=%h want v=1 pc=00000100 ins=%h",
                             id_valid, id_pc, id_instr, 32'h100 ^ KEY); else pass_cnt++;
            end
        end
    endtask

    // Redirect in the same cycle as the ack: that word never reaches decode.
    task automatic test_redirect_ack();
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 9; i++) @(negedge clk);
        total_cnt++; if (imem_addr !== 32'h20) $display("FAIL ra_setup_addr: got %h want 00000020", imem_addr); else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            if (n == 1) begin
                total_cnt++; if ({imem_addr, id_valid} !== {32'h200, 1'b0})
                    $display("FAIL ra_newaddr: got addr=%h v=%b want addr=00000200 v=0", imem_addr, id_valid); else pass_cnt++;
            end else if (n == 2) begin
                total_cnt++; if (id_valid !== 1'b0) $display("FAIL ra_gap: got v=%b pc=%h want v=0", id_valid, id_pc); else pass_cnt++;
            end else begin
                total_cnt++; if ({id_valid, id_pc} !== {1'b1, 32'h200})
                    $display("FAIL ra_first: got v=%b pc=%h want v=1 pc=00000200", id_valid, id_pc); else pass_cnt++;
            end
        end
    endtask

    // Redirect wins over a stall.
    task automatic test_redirect_stall();
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        total_cnt++; if (id_valid !== 1'b1) $display("FAIL rs_setup_valid: got %b want 1", id_valid); else pass_cnt++;
        id_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        id_stall = 1'b0; redirect_valid = 1'b0;
        total_cnt++; if ({id_valid, imem_addr} !== {1'b0, 32'h40})
            $display("FAIL rs_flush: got v=%b addr=%h want v=0 addr=00000040", id_valid, imem_addr); else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++; if ({id_valid, id_pc, id_pc_plus4} !== {1'b1, 32'h40, 32'h44})
            $display("FAIL rs_first: got v=%b pc=%h p4=%h want v=1 pc=00000040 p4=00000044", id_valid, id_pc, id_pc_plus4); else pass_cnt++;
    endtask

    // Asynchronous reset during a pending request; a stray ack afterwards is ignored.
    task automatic test_async_reset();
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        total_cnt++; if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0C, 1'b1})
            $display("FAIL ar_pending: got req=%b addr=%h v=%b want req=1 addr=0000000c v=1", imem_req, imem_addr, id_valid); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({imem_req, id_valid, imem_addr, id_pc} !== {1'b0, 1'b0, RST_PC, 32'h0})
            $display("FAIL ar_async: got req=%b v=%b addr=%h pc=%h want req=0 v=0 addr=%h pc=0",
                     imem_req, id_valid, imem_addr, id_pc, RST_PC); else pass_cnt++;
        imem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if ({imem_req, imem_addr, id_valid} !== {1'b1, RST_PC, 1'b0})
            $display("FAIL ar_restart: got req=%b addr=%h v=%b want req=1 addr=%h v=0", imem_req, imem_addr, id_valid, RST_PC); else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++; if ({id_valid, id_pc, imem_addr} !== {1'b1, RST_PC, RST_PC + 32'd8})
            $display("FAIL ar_first: got v=%b pc=%h addr=%h want v=1 pc=%h addr=%h",
                     id_valid, id_pc, imem_addr, RST_PC, RST_PC + 32'd8); else pass_cnt++;
    endtask

`ifdef IF_BUBBLE_CNT_EN
    task automatic test_bubble();
        rst = 1'b1; imem_ack = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (bubble_cnt !== 32'd0) $display("FAIL bub_reset: got %0d want 0", bubble_cnt); else pass_cnt++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (bubble_cnt !== 32'd3) $display("FAIL bub_idle: got %0d want 3", bubble_cnt); else pass_cnt++;
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (bubble_cnt !== 32'd4) $display("FAIL bub_stream: got %0d want 4", bubble_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_redirect_stall();
        test_async_reset();
`ifdef IF_BUBBLE_CNT_EN
        test_bubble();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
- Instruction-fetch stage of the five-stage pipeline CPU; sits directly upstream of the decode stage and produces the IF/ID pipeline register contents.
- Owns the fetch PC and issues word fetches to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned instructions in a small FIFO so decode stalls do not lose fetches.
- Accepts branch/jump redirects from downstream and flushes everything fetched on the wrong path.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, fetch buffer entries; legal values 2 or 4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0
imem_ack  input  1  memory returns data this cycle; may assert in the same cycle as imem_req
imem_rdata  input  32  instruction word; sampled only when imem_ack=1
redirect_valid  input  1  one-cycle pulse: flush and refetch from redirect_pc
redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced to 0)
id_stall  input  1  decode cannot accept a new instruction this cycle
id_valid  output  1  IF/ID register holds a valid instruction
id_instr  output  32  IF/ID instruction
id_pc  output  32  IF/ID instruction address
id_pc_plus4  output  32  id_pc + 4, modulo 2^32

Behaviour:
- Reset (async, active-high):
  - fetch_pc=RESET_PC; FIFO empty (count=0); state=FETCH.
  - imem_req=0; imem_addr=RESET_PC.
  - id_valid=0; id_instr=0; id_pc=0; id_pc_plus4=0.
- Handshake:
  - Exactly one request outstanding at most.
  - Once imem_req=1, imem_req and imem_addr hold stable until the cycle imem_ack=1.
  - imem_ack with imem_req=0 is ignored.
- States:
  - FETCH:
    - imem_req = (count < FIFO_DEPTH); imem_addr = fetch_pc.
    - On ack, push {fetch_pc, imem_rdata} into the FIFO and set fetch_pc += 4 (wraps at 2^32).
    - A new request may issue the next cycle, giving 1 fetch/cycle with zero-wait memory.
  - DISCARD: entered when redirect_valid=1 while a request is pending and imem_ack=0.
    - imem_req stays 1 with the old address.
    - On ack, data is dropped and state returns to FETCH.
    - fetch_pc already holds the redirect target.
- IF/ID register:
  - Loads when id_stall=0 or id_valid=0.
  - On load: if the FIFO is non-empty, pop the head into id_instr/id_pc, set id_pc_plus4=head.pc+4 and id_valid=1; otherwise id_valid=0.
  - id_instr/id_pc keep their previous values when id_valid goes to 0.
  - When id_stall=1 and id_valid=1, all id_* outputs hold.
- Latency: ack in cycle N -> FIFO entry at end of N -> id_valid=1 at end of N+1 (if not stalled).
- FIFO:
  - Push and pop in the same cycle are legal; count is unchanged.
  - The request gate uses the pre-pop count, which is conservative and never overflows.
- Redirect (highest priority, overrides id_stall):
  - Next edge: FIFO cleared, id_valid=0, fetch_pc={redirect_pc[31:2],2'b00}.
  - Pending request:
    - acked in the redirect cycle: data is dropped and state stays FETCH.
    - not acked: go to DISCARD.
  - Redirect while already in DISCARD: update fetch_pc only.
  - A push in the redirect cycle is suppressed.
- Reset mid-handshake: all state returns to reset values immediately. A later stray ack is ignored because imem_req=0.

Optional Feature:
- Macro IF_BUBBLE_CNT_EN.
- Defined:
  - Adds output port bubble_cnt (32 bits), reset to 0.
  - Increments (saturating at 32'hFFFF_FFFF) on every cycle the IF/ID register loads with the FIFO empty while no redirect is active.
  - This counts fetch-starvation bubbles.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, imem_ack tied 1 -> imem_addr 0x0,0x4,0x8,... on consecutive cycles; id_valid=1 from second cycle after first ack; id_pc 0x0,0x4,0x8 with id_pc_plus4 0x4,0x8,0xC; no gaps.
- ack=1, id_stall=1 for 6 cycles while id_pc=0x4 -> id_* hold at 0x4; imem_req drops once FIFO holds FIFO_DEPTH entries; after release id_pc continues 0x8,0xC with none lost or duplicated.
- Request to 0x10 with ack delayed 3 cycles, redirect_valid with redirect_pc=0x103 in first wait cycle -> imem_addr stays 0x10 until ack, that data discarded, next imem_addr=0x100, id_valid=0 the cycle after redirect, first valid id_pc=0x100.
- redirect_valid to 0x200 in same cycle as ack for 0x20 -> instruction at 0x20 never reaches id_valid=1; next imem_addr=0x200.
- redirect_valid and id_stall both 1 with id_valid=1 -> id_valid=0 next cycle (redirect wins).
- rst asserted asynchronously mid-wait -> imem_req=0, id_valid=0 without a clock edge; after release imem_addr=RESET_PC; with IF_BUBBLE_CNT_EN defined, bubble_cnt reads 0 then counts ack-gap cycles exactly.
